// File: rtl/pbit_field_accum_pkg.sv
// pbit_field_accum_pkg: shared encodings for the p-bit field accumulator
// Holds the FSM state encoding, spin encoding and Q-format/address helpers.
package pbit_field_accum_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ADD   = 2'd2,
      DONE  = 2'd3
   } state_t;
   localparam logic SPIN_POS = 1'b1;
   localparam logic SPIN_NEG = 1'b0;
   function automatic int addr_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic logic [63:0] q_one(input int q);
      return 64'd1 << q;
   endfunction
endpackage

// File: rtl/pbit_field_accum_if.sv
// pbit_field_accum_if: request/result and weight RAM signals of the field accumulator
// master: requester + weight RAM side; slave: the accumulator.
//   start/bias/spins : request, captured on accepted start
//   w_addr/w_rd_en   : weight RAM read request; w_data returns one cycle later
//   busy/done/sum/ovf: status and result
interface pbit_field_accum_if
   import pbit_field_accum_pkg::*;
#(
   parameter int N      = 32,
   parameter int N_SPIN = 8
);
   localparam int AW = addr_w(N_SPIN);
   logic              start;
   logic [N-1:0]      bias;
   logic [N_SPIN-1:0] spins;
   logic [AW-1:0]     w_addr;
   logic              w_rd_en;
   logic [N-1:0]      w_data;
   logic              busy;
   logic              done;
   logic [N-1:0]      sum;
   logic              ovf;
   modport master (
      output start, bias, spins, w_data,
      input  w_addr, w_rd_en, busy, done, sum, ovf
   );
   modport slave (
      input  start, bias, spins, w_data,
      output w_addr, w_rd_en, busy, done, sum, ovf
   );
endinterface

// File: rtl/pbit_field_accum_qadd.sv
// qadd: combinational sign-magnitude Q-format adder
//   a, b : sign-magnitude operands (bit N-1 = sign)
//   c    : sign-magnitude result, never -0
//   ovr  : magnitude overflow (only possible for like signs)
module qadd #(
   parameter int Q = 15,
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] c,
   output logic         ovr
);
   if (Q >= N - 1) begin : g_bad_q
      $error("qadd: Q must be smaller than N-1");
   end
   logic [N-1:0] msum;
   logic         same;
   logic         a_ge;
   logic [N-2:0] mag;
   logic         sgn;
   always_comb begin
      msum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
      same = a[N-1] == b[N-1];
      a_ge = a[N-2:0] >= b[N-2:0];
      mag  = same ? msum[N-2:0] : a_ge ? a[N-2:0] - b[N-2:0] : b[N-2:0] - a[N-2:0];
      sgn  = same ? a[N-1] : a_ge ? a[N-1] : b[N-1];
      ovr  = same & msum[N-1];
      c    = {sgn & |mag, mag};
   end
endmodule

// File: rtl/pbit_field_accum.sv
// pbit_field_accum: sequential local-field accumulator I = bias + sum_j(m_j * W_j)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of pbit_field_accum_if (request, weight RAM, result)
module pbit_field_accum
   import pbit_field_accum_pkg::*;
#(
   parameter int N      = 32,
   parameter int Q      = 15,
   parameter int N_SPIN = 8
) (
   input  logic               clk,
   input  logic               rst,
   pbit_field_accum_if.slave  bus
);
   localparam int AW = addr_w(N_SPIN);
   state_t            state, nxt;
   logic [AW-1:0]     idx;
   logic [AW-1:0]     addr_q;
   logic [N_SPIN-1:0] spin_q;
   logic [N-1:0]      acc;
   logic              ovf_q;
   logic [N-1:0]      op;
   logic [N-1:0]      qsum;
   logic              qovr;
   logic              last;
   qadd #(.Q(Q), .N(N)) u_qadd (
      .a   (acc),
      .b   (op),
      .c   (qsum),
      .ovr (qovr)
   );
   // A -1 spin flips the weight sign; a zero weight stays +0.
   always_comb begin
      op   = {|bus.w_data[N-2:0] & (bus.w_data[N-1] ^ (spin_q[idx] == SPIN_NEG)), bus.w_data[N-2:0]};
      last = idx == AW'(N_SPIN - 1);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = bus.start ? FETCH : IDLE;
         FETCH:   nxt = ADD;
         ADD:     nxt = last ? DONE : FETCH;
         default: nxt = IDLE;
      endcase
   end
   // Address is driven live during FETCH and held afterwards.
   always_comb begin
      bus.w_rd_en = state == FETCH;
      bus.w_addr  = state == FETCH ? idx : addr_q;
      bus.busy    = state == FETCH || state == ADD;
      bus.done    = state == DONE;
      bus.sum     = acc;
      bus.ovf     = ovf_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc    <= '0;
         ovf_q  <= 1'b0;
         idx    <= '0;
         spin_q <= '0;
         addr_q <= '0;
      end else begin
         if (state == IDLE && bus.start) begin
            acc    <= bus.bias;
            spin_q <= bus.spins;
            idx    <= '0;
            ovf_q  <= 1'b0;
         end
         if (state == FETCH) addr_q <= idx;
         if (state == ADD) begin
            acc   <= qovr ? {acc[N-1], {(N-1){1'b1}}} : qsum;
            ovf_q <= ovf_q | qovr;
            if (!last) idx <= idx + 1'b1;
         end
      end
endmodule

// File: tb/tb_pbit_field_accum.sv
// tb_pbit_field_accum: directed table-driven check of the field accumulator
module tb_pbit_field_accum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   pbit_field_accum_if #(.N(32), .N_SPIN(4)) bus ();
   pbit_field_accum #(.N(32), .Q(15), .N_SPIN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   logic [31:0] wmem [4];
   always @(posedge clk) if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];
   typedef struct {
      logic [3:0][31:0] w;
      logic [3:0]       spins;
      logic [31:0]      bias;
      logic [31:0]      sum;
      logic             ovf;
      bit               spam;
   } vec_t;
   vec_t v [11];
   int total = 0;
   int bad = 0;
   int lat, busy_n, done_n;
   logic [1:0] addrs [$];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask
   task automatic run(input vec_t x);
      for (int i = 0; i < 4; i++) wmem[i] = x.w[i];
      lat = 0;
      busy_n = 0;
      done_n = 0;
      addrs.delete();
      @(negedge clk);
      bus.start = 1'b1;
      bus.bias  = x.bias;
      bus.spins = x.spins;
      @(posedge clk);
      for (int k = 1; k <= 40 && (lat == 0 || k <= lat + 3); k++) begin
         #1;
         if (bus.done) begin
            done_n++;
            if (lat == 0) lat = k;
         end
         if (bus.busy) busy_n++;
         if (bus.w_rd_en) addrs.push_back(bus.w_addr);
         bus.start = x.spam && lat == 0;
         if (x.spam) begin
            bus.bias  = 32'h1234_5678;
            bus.spins = ~x.spins;
         end
         @(posedge clk);
      end
      #1;
      bus.start = 1'b0;
   endtask
   task automatic run_chk(input vec_t x, input int id);
      run(x);
      chk($sformatf("v%0d sum", id), bus.sum, x.sum);
      chk($sformatf("v%0d ovf", id), 32'(bus.ovf), 32'(x.ovf));
      chk($sformatf("v%0d latency", id), lat, 9);
      chk($sformatf("v%0d done pulses", id), done_n, 1);
      chk($sformatf("v%0d busy cycles", id), busy_n, 8);
      chk($sformatf("v%0d addr count", id), addrs.size(), 4);
      for (int i = 0; i < addrs.size() && i < 4; i++)
         chk($sformatf("v%0d addr%0d", id, i), 32'(addrs[i]), i);
   endtask
   initial begin
      bus.start = 1'b0;
      bus.bias  = '0;
      bus.spins = '0;
      v[0]  = '{{4{32'h0000_8000}}, 4'b1111, 32'h0000_0000, 32'h0002_0000, 1'b0, 1'b0};
      v[1]  = '{{4{32'h0000_8000}}, 4'b0000, 32'h0000_4000, 32'h8001_C000, 1'b0, 1'b0};
      v[2]  = '{{4{32'h0000_8000}}, 4'b0101, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      v[3]  = '{{4{32'h7FFF_FFFF}}, 4'b1111, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
      v[4]  = '{{4{32'h0000_0000}}, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      v[5]  = '{{4{32'h7FFF_FFFF}}, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0};
      v[6]  = '{{4{32'h0000_0000}}, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
      v[7]  = '{{32'h0000_2000, 32'h0000_4000, 32'h0001_0000, 32'h0000_8000}, 4'b0110, 32'h0000_0000, 32'h0000_A000, 1'b0, 1'b0};
      v[8]  = '{{32'h0000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, 4'b1011, 32'h0000_0000, 32'h7FFF_7FFF, 1'b1, 1'b0};
      v[9]  = '{{4{32'h0000_8000}}, 4'b1111, 32'h8000_4000, 32'h0001_C000, 1'b0, 1'b0};
      v[10] = '{{4{32'h0000_8000}}, 4'b1111, 32'h0000_0000, 32'h0002_0000, 1'b0, 1'b1};
      #2;
      chk("reset ctrl", {28'd0, bus.w_rd_en, bus.busy, bus.done, bus.ovf}, 32'd0);
      chk("reset addr", 32'(bus.w_addr), 32'd0);
      chk("reset sum", bus.sum, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle hold", {28'd0, bus.w_rd_en, bus.busy, bus.done, bus.ovf}, 32'd0);
      for (int i = 0; i < 11; i++) run_chk(v[i], i);
      for (int i = 0; i < 4; i++) wmem[i] = 32'h0000_8000;
      @(negedge clk);
      bus.start = 1'b1;
      bus.bias  = 32'h0000_4000;
      bus.spins = 4'b1111;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre-rst busy", 32'(bus.busy), 32'd1);
      chk("pre-rst sum", bus.sum, 32'h0001_4000);
      chk("pre-rst addr", 32'(bus.w_addr), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst ctrl", {28'd0, bus.w_rd_en, bus.busy, bus.done, bus.ovf}, 32'd0);
      chk("async rst addr", 32'(bus.w_addr), 32'd0);
      chk("async rst sum", bus.sum, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst idle", {28'd0, bus.w_rd_en, bus.busy, bus.done, bus.ovf}, 32'd0);
      run_chk(v[0], 100);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
